// File: rtl/divider_iter_if.sv
// Handshake/operand bundle for divider_iter. The master drives requests, the slave returns results.
interface divider_iter_if #(
  parameter int unsigned WIDTH = 8
);
  logic             i_begin;
  logic             i_signed;
  logic             i_abort;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             o_busy;
  logic             o_done;
  logic             o_divZero;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;

  modport master (
    output i_begin, i_signed, i_abort, i_dividend, i_divisor,
    input  o_busy, o_done, o_divZero, o_quotient, o_remainder
  );

  modport slave (
    input  i_begin, i_signed, i_abort, i_dividend, i_divisor,
    output o_busy, o_done, o_divZero, o_quotient, o_remainder
  );
endinterface

// File: rtl/divider_iter.sv
// Iterative restoring divider that retires BITS_PER_CYCLE quotient bits per cycle.
// Signed/unsigned per operation, abortable, fixed latency of WIDTH/BITS_PER_CYCLE + 2 cycles.
module divider_iter #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input logic          i_clk,
  input logic          i_rst,
  input logic          i_cg,
  divider_iter_if.slave bus
);
  localparam int unsigned N     = WIDTH / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(N - 1);

  if ((WIDTH < 2) || !((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) || (BITS_PER_CYCLE == 4))
      || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_bad_cfg
    $error("divider_iter: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH:0]   stg_rem;
  logic [WIDTH-1:0] stg_quo;

  // Operand magnitudes; the most negative value maps onto its own unsigned magnitude.
  always_comb begin
    dvd_mag = bus.i_dividend;
    dvs_mag = bus.i_divisor;
    if (bus.i_signed && bus.i_dividend[WIDTH-1]) dvd_mag = WIDTH'(-bus.i_dividend);
    if (bus.i_signed && bus.i_divisor[WIDTH-1])  dvs_mag = WIDTH'(-bus.i_divisor);
  end

  // Cascaded restoring stages; quo_q shifts dividend bits out as quotient bits shift in.
  always_comb begin
    stg_rem = rem_q;
    stg_quo = quo_q;
    for (int unsigned s = 0; s < BITS_PER_CYCLE; s++) begin
      stg_rem = {stg_rem[WIDTH-1:0], stg_quo[WIDTH-1]};
      stg_quo = {stg_quo[WIDTH-2:0], 1'b0};
      if (stg_rem >= {1'b0, dvs_q}) begin
        stg_rem    = stg_rem - {1'b0, dvs_q};
        stg_quo[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    dz_d        = dz_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    divzero_d   = divzero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    case (state_q)
      S_IDLE: begin
        if (bus.i_begin) begin
          state_d = S_CALC;
          cnt_d   = CNT_LOAD;
          rem_d   = '0;
          quo_d   = dvd_mag;
          dvs_d   = dvs_mag;
          qneg_d  = bus.i_signed & (bus.i_dividend[WIDTH-1] ^ bus.i_divisor[WIDTH-1]);
          rneg_d  = bus.i_signed & bus.i_dividend[WIDTH-1];
          dz_d    = (bus.i_divisor == '0);
        end
      end
      S_CALC: begin
        if (bus.i_abort) begin
          state_d = S_IDLE;
        end else begin
          rem_d = stg_rem;
          quo_d = stg_quo;
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        if (!bus.i_abort) begin
          done_d    = 1'b1;
          divzero_d = dz_q;
          // With a zero divisor the remainder path reconstructs the original dividend.
          quotient_d  = dz_q ? '1 : (qneg_q ? WIDTH'(-quo_q) : quo_q);
          remainder_d = rneg_q ? WIDTH'(-rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      dz_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      divzero_q   <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else if (i_cg) begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      dz_q        <= dz_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      divzero_q   <= divzero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign bus.o_busy      = busy_q;
  assign bus.o_done      = done_q;
  assign bus.o_divZero   = divzero_q;
  assign bus.o_quotient  = quotient_q;
  assign bus.o_remainder = remainder_q;
endmodule
